// File: rtl/fifo_reader.sv
// Purpose : pulls words from an upstream FIFO with fixed read latency and presents them on a valid/ready output.
// Latency : fifo_rd_en in cycle t -> captured at end of cycle t+RD_LATENCY -> m_valid from cycle t+RD_LATENCY+1.
// Backpressure: reads are issued only while buffer occupancy plus in-flight reads is below BUF_DEPTH, so m_ready=0 stalls
//               reads without ever dropping a word.
//
// Ports:
//   clk, rst          single clock, synchronous active-high reset (priority over everything)
//   enable            permits issuing new reads (IDLE->RUN, RUN<->DRAIN)
//   fifo_empty        upstream FIFO empty flag
//   fifo_data         upstream read data, valid RD_LATENCY cycles after fifo_rd_en
//   fifo_rd_en        upstream read request
//   m_valid, m_data   output word, m_ready accepts it
//   busy              controller not in IDLE
//   words_out         delivered-word counter when FIFO_READER_STATS_EN is defined, else tied to 0
//
// Optional feature macro: FIFO_READER_STATS_EN

module fifo_reader #(
    parameter int RD_LATENCY = 2,
    parameter int BUF_DEPTH  = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        fifo_empty,
    input  logic [7:0]  fifo_data,
    output logic        fifo_rd_en,
    output logic        m_valid,
    output logic [7:0]  m_data,
    input  logic        m_ready,
    output logic        busy,
    output logic [15:0] words_out
);

    localparam int PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    // Wide enough to hold occupancy + in-flight count without overflow.
    localparam int CW = PW + 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t                state;
    logic [RD_LATENCY-1:0] inflight;
    logic [PW-1:0]         head;
    logic [PW-1:0]         tail;
    logic [PW:0]           occ;
    logic [7:0]            mem [BUF_DEPTH];
    logic [CW-1:0]         inflight_cnt;
    logic                  capture;
    logic                  xfer;

    always_comb begin
        inflight_cnt = '0;
        for (int i = 0; i < RD_LATENCY; i++) begin
            inflight_cnt = inflight_cnt + CW'(inflight[i]);
        end
    end

    // The last shift stage marks the one cycle where fifo_data belongs to us.
    assign capture = inflight[RD_LATENCY-1];
    assign m_valid = (occ != '0);
    assign xfer    = m_valid && m_ready;
    assign busy    = (state != IDLE);
    // Head entry only; no bypass from fifo_data.
    assign m_data  = m_valid ? mem[head] : 8'h00;

    // Credit check counts in-flight reads as already occupying buffer slots.
    assign fifo_rd_en = !rst && (state == RUN) && !fifo_empty
                        && ((CW'(occ) + inflight_cnt) < CW'(BUF_DEPTH));

    // Controller
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE:    if (enable) state <= RUN;
                RUN:     if (!enable) state <= DRAIN;
                DRAIN: begin
                    if (enable) begin
                        state <= RUN;
                    end else if ((inflight == '0) && (occ == '0)) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // In-flight tracking and circular buffer pointers
    always_ff @(posedge clk) begin
        if (rst) begin
            inflight <= '0;
            head     <= '0;
            tail     <= '0;
            occ      <= '0;
        end else begin
            inflight[0] <= fifo_rd_en;
            for (int i = 1; i < RD_LATENCY; i++) begin
                inflight[i] <= inflight[i-1];
            end
            if (capture) tail <= tail + 1'b1;
            if (xfer)    head <= head + 1'b1;
            // Simultaneous capture and transfer leaves occupancy alone, even when full.
            case ({capture, xfer})
                2'b10:   occ <= occ + 1'b1;
                2'b01:   occ <= occ - 1'b1;
                default: occ <= occ;
            endcase
        end
    end

    // Storage needs no reset: m_data is masked while the buffer is empty.
    always_ff @(posedge clk) begin
        if (!rst && capture) begin
            mem[tail] <= fifo_data;
        end
    end

`ifdef FIFO_READER_STATS_EN
    logic [15:0] word_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            word_cnt <= '0;
        end else if (xfer) begin
            word_cnt <= word_cnt + 16'd1;
        end
    end

    assign words_out = word_cnt;
`else
    assign words_out = 16'h0000;
`endif

endmodule

// File: doc/fifo_reader.md
FIFO_READER -- requirements
Module: fifo_reader

Interface
REQ-001: Parameter RD_LATENCY, default 2, sets the cycles from fifo_rd_en asserted to fifo_data valid; legal range 1..3.
REQ-002: Parameter BUF_DEPTH, default 4, sets the output holding-buffer entries; power of 2, at least RD_LATENCY+2.
REQ-003: clk  input  1  the single clock; all state SHALL update on its rising edge.
REQ-004: rst  input  1  synchronous, active-high reset.
REQ-005: enable  input  1  permits issuing new FIFO reads.
REQ-006: fifo_empty  input  1  empty flag from the upstream FIFO.
REQ-007: fifo_data  input  8  read data from the upstream FIFO.
REQ-008: fifo_rd_en  output  1  read request to the upstream FIFO.
REQ-009: m_valid  output  1  output word available.
REQ-010: m_data  output  8  output word.
REQ-011: m_ready  input  1  downstream accepts the word.
REQ-012: busy  output  1  high whenever the state is not IDLE.
REQ-013: words_out  output  16  count of delivered words (see Configuration).

Function
REQ-014: The controller SHALL have three states: IDLE, RUN and DRAIN.
REQ-015: Transitions SHALL be IDLE->RUN when enable=1, RUN->DRAIN when enable=0, and DRAIN->RUN when enable=1.
REQ-016: DRAIN->IDLE SHALL occur when enable=0, no reads are in flight and the buffer is empty.
REQ-017: fifo_rd_en SHALL equal (state==RUN) && !fifo_empty && (buffer occupancy + in-flight reads < BUF_DEPTH), decoded combinationally from registered state.
REQ-018: In-flight reads SHALL be tracked by an RD_LATENCY-stage valid shift register.
REQ-019: fifo_data SHALL be captured into the buffer on the cycle the final shift stage is set, exactly RD_LATENCY cycles after the rd_en cycle.
REQ-020: fifo_data SHALL be ignored on all other cycles.
REQ-021: The buffer SHALL be a circular queue with wrapping log2(BUF_DEPTH)-bit pointers and a separate occupancy count of log2(BUF_DEPTH)+1 bits.
REQ-022: m_valid SHALL be 1 exactly when occupancy>0, and m_data SHALL present the head entry.
REQ-023: There SHALL be no bypass path: rd_en in cycle t gives m_valid no earlier than cycle t+RD_LATENCY+1.
REQ-024: A transfer SHALL occur when m_valid && m_ready; the head pointer SHALL then advance.
REQ-025: m_data SHALL stay stable while m_valid=1 and m_ready=0.
REQ-026: A capture and a transfer in the same cycle SHALL leave occupancy unchanged, including when the buffer is full.
REQ-027: The buffer SHALL never overflow; the credit rule in REQ-017 guarantees this.
REQ-028: Words SHALL be delivered in FIFO read order with no loss or duplication.
REQ-029: With m_ready held 1 and the FIFO non-empty, throughput SHALL be one word per cycle.
REQ-030: In DRAIN, in-flight and buffered words SHALL still be captured and delivered.

Reset
REQ-031: While rst=1: state IDLE, fifo_rd_en=0, m_valid=0, m_data=0x00, busy=0, words_out=0, pointers, occupancy and in-flight stages all 0.
REQ-032: rst SHALL take priority over every other input.
REQ-033: A mid-operation rst SHALL discard buffered and in-flight words; FIFO data arriving afterwards SHALL be ignored.

Configuration
REQ-034: The macro FIFO_READER_STATS_EN SHALL control the delivered-word counter.
REQ-035: With FIFO_READER_STATS_EN defined, words_out SHALL increment by 1 per transfer and wrap from 0xFFFF to 0x0000.
REQ-036: Without FIFO_READER_STATS_EN, the port SHALL remain present, tied to 0, with no counter logic.

Verification
REQ-037: Reset: rst=1 for 2 cycles with enable=1 and fifo_empty=0 -> fifo_rd_en=0, m_valid=0, busy=0, words_out=0 throughout.
REQ-038: Stream: FIFO holds 0x01..0x05, enable=1, m_ready=1, first rd_en in cycle t -> m_data 0x01..0x05 in cycles t+3..t+7 with m_valid continuous, then rd_en=0 once fifo_empty=1.
REQ-039: Backpressure: 10 words queued, m_ready=0 -> exactly 4 rd_en pulses and buffer holds 0x01..0x04; raising m_ready -> remaining words delivered in order with no gap after the pipeline refills.
REQ-040: Drain: enable dropped with 2 reads in flight -> no further rd_en, both words delivered, then busy=0 and state IDLE.
REQ-041: Mid-op reset: rst pulsed with 3 buffered words -> m_valid=0 the next cycle and old words never appear; a new enable fetches fresh data correctly.
REQ-042: Stats: 300 transfers with the macro defined -> words_out=0x012C; without the macro -> words_out=0 throughout.
